// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
// Shared definitions for the run/single-step controller:
//   state_t          - controller FSM states
//   SYNC_DEPTH       - flops in each input synchroniser
//   LIMIT_W          - counter width that covers DEBOUNCE and STEP_BURST
//   DEBOUNCE_MIN/MAX, STEP_BURST_MIN/MAX - legal parameter ranges
package step_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_STEP_IDLE  = 2'd1,
      ST_STEP_BURST = 2'd2
   } state_t;

   localparam int SYNC_DEPTH     = 2;
   localparam int LIMIT_W        = 8;
   localparam int DEBOUNCE_MIN   = 1;
   localparam int DEBOUNCE_MAX   = 255;
   localparam int STEP_BURST_MIN = 1;
   localparam int STEP_BURST_MAX = 255;

endpackage

// File: rtl/step_ctrl_sync_debounce.sv
// sync_debounce
// Brings one raw asynchronous level into the clock domain, debounces it and
// emits a single-cycle pulse when the debounced level rises.
// Parameters:
//   DEBOUNCE - consecutive cycles the synchronised level must differ from the
//              debounced level before the debounced level follows it (1..255)
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   din   - raw asynchronous input
//   rise  - registered 1-cycle pulse on each accepted 0->1 transition
module sync_debounce
   import step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   localparam logic [LIMIT_W-1:0] CNT_LAST = LIMIT_W'(DEBOUNCE - 1);

   logic [SYNC_DEPTH-1:0] sync_p;
   logic [LIMIT_W-1:0]    cnt_q;
   logic                  level_q;
   logic                  sync_lvl;

   assign sync_lvl = sync_p[SYNC_DEPTH-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_p  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         // synchroniser shift: sync_p[0] is the metastability-catching flop
         sync_p <= {sync_p[SYNC_DEPTH-2:0], din};
         rise   <= 1'b0;
         // any cycle where the levels agree restarts the stability count
         if (sync_lvl != level_q) begin
            if (cnt_q == CNT_LAST) begin
               level_q <= sync_lvl;
               cnt_q   <= '0;
               rise    <= sync_lvl;
            end else begin
               cnt_q <= cnt_q + LIMIT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl
// Run/single-step controller producing the per-cycle advance enable for the
// downstream pipeline. In RUN the pipeline free-runs; in step mode each
// accepted step edge releases STEP_BURST advance cycles.
// Optional feature macro: STEP_CTRL_BREAK_EN adds a PC breakpoint that drops
// from RUN into step mode when pc matches break_addr.
// Parameters: DEBOUNCE (1..255), STEP_BURST (1..255), CNT_W, PC_W
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-low reset
//   change      - raw async run/step mode toggle (rising edge)
//   step        - raw async step request (rising edge)
//   advance     - registered pipeline enable
//   mode_step   - 0 = RUN, 1 = step mode
//   busy        - step burst in progress
//   step_count  - accepted step edges since reset, wraps
//   pc, break_addr, break_valid, break_hit - breakpoint (STEP_CTRL_BREAK_EN)
module step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE   = 4,
   parameter int STEP_BURST = 1,
   parameter int CNT_W      = 16,
   parameter int PC_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             change,
   input  logic             step,
`ifdef STEP_CTRL_BREAK_EN
   input  logic [PC_W-1:0]  pc,
   input  logic [PC_W-1:0]  break_addr,
   input  logic             break_valid,
   output logic             break_hit,
`endif
   output logic             advance,
   output logic             mode_step,
   output logic             busy,
   output logic [CNT_W-1:0] step_count
);

   localparam logic [LIMIT_W-1:0] BURST_LOAD = LIMIT_W'(STEP_BURST);

   // An out-of-range build shows up by this block name in the hierarchy.
   if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX ||
       STEP_BURST < STEP_BURST_MIN || STEP_BURST > STEP_BURST_MAX ||
       CNT_W < 1 || PC_W < 1) begin : g_param_range_violation
   end

   logic chg_rise;
   logic stp_rise;

   sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_change_db (
      .clock (clock),
      .reset (reset),
      .din   (change),
      .rise  (chg_rise)
   );

   sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
      .clock (clock),
      .reset (reset),
      .din   (step),
      .rise  (stp_rise)
   );

   state_t             state_q, state_d;
   logic [LIMIT_W-1:0] burst_q, burst_d;
   logic [CNT_W-1:0]   count_d;
   logic               advance_d, mode_d, busy_d;
`ifdef STEP_CTRL_BREAK_EN
   logic               hit_d;
`endif

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      count_d = step_count;
`ifdef STEP_CTRL_BREAK_EN
      hit_d   = break_hit;
`endif
      case (state_q)
         ST_RUN: begin
            if (chg_rise) begin
               state_d = ST_STEP_IDLE;
`ifdef STEP_CTRL_BREAK_EN
            end else if (advance && break_valid && (pc == break_addr)) begin
               state_d = ST_STEP_IDLE;
               hit_d   = 1'b1;
`endif
            end
         end
         ST_STEP_IDLE: begin
            // change outranks a step arriving in the same cycle
            if (chg_rise) begin
               state_d = ST_RUN;
            end else if (stp_rise) begin
               state_d = ST_STEP_BURST;
               burst_d = BURST_LOAD;
               count_d = step_count + CNT_W'(1);
            end
         end
         ST_STEP_BURST: begin
            // step pulses are deliberately ignored while a burst is running
            if (chg_rise) begin
               state_d = ST_RUN;
               burst_d = '0;
            end else begin
               burst_d = burst_q - LIMIT_W'(1);
               if (burst_q == LIMIT_W'(1)) begin
                  state_d = ST_STEP_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            burst_d = '0;
         end
      endcase
`ifdef STEP_CTRL_BREAK_EN
      if (chg_rise) begin
         hit_d = 1'b0;
      end
`endif
      // outputs are registered copies decoded from the next state
      advance_d = (state_d != ST_STEP_IDLE);
      mode_d    = (state_d != ST_RUN);
      busy_d    = (state_d == ST_STEP_BURST);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         burst_q    <= '0;
         step_count <= '0;
         advance    <= 1'b0;
         mode_step  <= 1'b0;
         busy       <= 1'b0;
`ifdef STEP_CTRL_BREAK_EN
         break_hit  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         step_count <= count_d;
         advance    <= advance_d;
         mode_step  <= mode_d;
         busy       <= busy_d;
`ifdef STEP_CTRL_BREAK_EN
         break_hit  <= hit_d;
`endif
      end
   end

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl
// Three controller instances share one set of raw inputs:
//   dut_a - DEBOUNCE=4, STEP_BURST=1, CNT_W=16
//   dut_b - DEBOUNCE=4, STEP_BURST=3, CNT_W=4
//   dut_c - DEBOUNCE=1, STEP_BURST=3 (short latency for mid-burst sequences)
// Breakpoint sequence is compiled in when STEP_CTRL_BREAK_EN is defined.
module tb_step_ctrl;

   logic        clock  = 1'b0;
   logic        reset  = 1'b0;
   logic        change = 1'b0;
   logic        step   = 1'b0;

   logic        adv_a, mode_a, busy_a;
   logic [15:0] cnt_a;
   logic        adv_b, mode_b, busy_b;
   logic [3:0]  cnt_b;
   logic        adv_c, mode_c, busy_c;
   logic [15:0] cnt_c;
`ifdef STEP_CTRL_BREAK_EN
   logic [31:0] pc          = '0;
   logic [31:0] break_addr  = '0;
   logic        break_valid = 1'b0;
   logic        hit_a, hit_b, hit_c;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   step_ctrl dut_a (
      .clock(clock), .reset(reset), .change(change), .step(step),
`ifdef STEP_CTRL_BREAK_EN
      .pc(pc), .break_addr(break_addr), .break_valid(break_valid), .break_hit(hit_a),
`endif
      .advance(adv_a), .mode_step(mode_a), .busy(busy_a), .step_count(cnt_a)
   );

   step_ctrl #(.STEP_BURST(3), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .change(change), .step(step),
`ifdef STEP_CTRL_BREAK_EN
      .pc(pc), .break_addr(break_addr), .break_valid(break_valid), .break_hit(hit_b),
`endif
      .advance(adv_b), .mode_step(mode_b), .busy(busy_b), .step_count(cnt_b)
   );

   step_ctrl #(.DEBOUNCE(1), .STEP_BURST(3)) dut_c (
      .clock(clock), .reset(reset), .change(change), .step(step),
`ifdef STEP_CTRL_BREAK_EN
      .pc(pc), .break_addr(break_addr), .break_valid(break_valid), .break_hit(hit_c),
`endif
      .advance(adv_c), .mode_step(mode_c), .busy(busy_c), .step_count(cnt_c)
   );

   // One stimulus window: raw inputs held for 'hold' edges, then 24 edges
   // observed in total. Expected: final mode, advance-cycle counts, busy
   // cycles on dut_b, final step counts.
   typedef struct {
      int id;
      bit chg;
      bit stp;
      int hold;
      bit mode;
      int adv_a;
      int adv_b;
      int busy_b;
      int cnt_a;
      int cnt_b;
   } vec_t;

   localparam int WIN = 24;

   vec_t sb_q[$];

   function automatic vec_t mk(int id, bit chg, bit stp, int hold, bit mode,
                               int adv_a, int adv_b, int busy_b, int cnt_a, int cnt_b);
      vec_t v;
      v.id = id; v.chg = chg; v.stp = stp; v.hold = hold; v.mode = mode;
      v.adv_a = adv_a; v.adv_b = adv_b; v.busy_b = busy_b;
      v.cnt_a = cnt_a; v.cnt_b = cnt_b;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply(input vec_t v);
      int   na, nb, bb;
      vec_t e;
      na = 0; nb = 0; bb = 0;
      sb_q.push_back(v);
      change = v.chg;
      step   = v.stp;
      for (int k = 1; k <= WIN; k++) begin
         tick();
         if (k == v.hold) begin
            change = 1'b0;
            step   = 1'b0;
         end
         na += adv_a ? 1 : 0;
         nb += adv_b ? 1 : 0;
         bb += busy_b ? 1 : 0;
      end
      if (sb_q.size() == 0) begin
         chk($sformatf("vec%0d_scoreboard_empty", v.id), 0, 1);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("vec%0d_adv_cycles_a", e.id), na, e.adv_a);
         chk($sformatf("vec%0d_adv_cycles_b", e.id), nb, e.adv_b);
         chk($sformatf("vec%0d_busy_cycles_b", e.id), bb, e.busy_b);
         chk($sformatf("vec%0d_mode_a", e.id), int'(mode_a), int'(e.mode));
         chk($sformatf("vec%0d_mode_b", e.id), int'(mode_b), int'(e.mode));
         chk($sformatf("vec%0d_count_a", e.id), int'(cnt_a), e.cnt_a);
         chk($sformatf("vec%0d_count_b", e.id), int'(cnt_b), e.cnt_b);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      int   n;

      // ---- reset held for 10 cycles, then released
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("reset_adv_a", int'(adv_a), 0);
      end
      chk("reset_adv_b", int'(adv_b), 0);
      chk("reset_adv_c", int'(adv_c), 0);
      chk("reset_mode_a", int'(mode_a), 0);
      chk("reset_busy_a", int'(busy_a), 0);
      chk("reset_count_a", int'(cnt_a), 0);
      chk("reset_count_b", int'(cnt_b), 0);
      reset = 1'b1;
      tick();
      chk("release_adv_a", int'(adv_a), 1);
      chk("release_adv_b", int'(adv_b), 1);
      chk("release_adv_c", int'(adv_c), 1);
      chk("release_mode_a", int'(mode_a), 0);

      // ---- table-driven windows, starting in RUN with counts at 0
      //          id chg stp hold mode adv_a adv_b busy_b cnt_a cnt_b
      tbl[0] = mk(0, 1,  0,  8,   1,   6,    6,    0,     0,    0); // RUN -> step at edge 7
      tbl[1] = mk(1, 0,  1,  8,   1,   1,    3,    3,     1,    1); // one accepted step
      tbl[2] = mk(2, 0,  1,  3,   1,   0,    0,    0,     1,    1); // 3-cycle glitch rejected
      tbl[3] = mk(3, 0,  1,  4,   1,   1,    3,    3,     2,    2); // exactly DEBOUNCE cycles
      tbl[4] = mk(4, 1,  1,  8,   0,  18,   18,    0,     2,    2); // change beats step
      tbl[5] = mk(5, 0,  1,  8,   0,  24,   24,    0,     2,    2); // step ignored in RUN
      tbl[6] = mk(6, 1,  0,  8,   1,   6,    6,    0,     2,    2); // back to step mode
      for (int i = 0; i < 7; i++) begin
         apply(tbl[i]);
      end

      // ---- 15 more steps: 17 in total, dut_b count wraps at 16
      for (int i = 0; i < 15; i++) begin
         n = 3 + i;
         apply(mk(10 + i, 0, 1, 8, 1, 1, 3, 3, n, n % 16));
      end

      // ---- dut_c sequences (DEBOUNCE=1 gives a 3-edge pulse latency)
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("c_release_adv", int'(adv_c), 1);

      change = 1'b1; tick(); change = 1'b0; tick(); tick();
      chk("c_run_before_pulse_adv", int'(adv_c), 1);
      tick();
      chk("c_enter_step_adv", int'(adv_c), 0);
      chk("c_enter_step_mode", int'(mode_c), 1);
      repeat (3) tick();

      // second step edge lands mid-burst and is dropped
      step = 1'b1; tick(); step = 1'b0; tick(); step = 1'b1; tick(); step = 1'b0;
      tick();
      chk("c_burst1_adv", int'(adv_c), 1);
      chk("c_burst1_busy", int'(busy_c), 1);
      chk("c_burst1_count", int'(cnt_c), 1);
      tick();
      chk("c_burst2_adv", int'(adv_c), 1);
      tick();
      chk("c_burst3_adv", int'(adv_c), 1);
      chk("c_burst3_busy", int'(busy_c), 1);
      tick();
      chk("c_burst_end_adv", int'(adv_c), 0);
      chk("c_burst_end_busy", int'(busy_c), 0);
      chk("c_dropped_step_count", int'(cnt_c), 1);
      tick();
      chk("c_no_second_burst_adv", int'(adv_c), 0);
      repeat (3) tick();

      // change pulse aborts a burst; advance stays high into RUN
      step = 1'b1; tick(); step = 1'b0; change = 1'b1; tick(); change = 1'b0; tick();
      tick();
      chk("c_abort_burst_busy", int'(busy_c), 1);
      chk("c_abort_count", int'(cnt_c), 2);
      tick();
      chk("c_abort_adv", int'(adv_c), 1);
      chk("c_abort_busy", int'(busy_c), 0);
      chk("c_abort_mode", int'(mode_c), 0);
      tick();
      chk("c_abort_run_adv", int'(adv_c), 1);
      repeat (3) tick();

      // reset asserted mid-burst
      change = 1'b1; tick(); change = 1'b0; tick(); tick(); tick();
      chk("c_rst_seq_mode", int'(mode_c), 1);
      repeat (3) tick();
      step = 1'b1; tick(); step = 1'b0; tick(); tick(); tick();
      chk("c_rst_seq_busy", int'(busy_c), 1);
      reset = 1'b0;
      #1;
      chk("c_async_rst_adv", int'(adv_c), 0);
      chk("c_async_rst_busy", int'(busy_c), 0);
      chk("c_async_rst_mode", int'(mode_c), 0);
      chk("c_async_rst_count", int'(cnt_c), 0);
      tick();
      reset = 1'b1;
      tick();
      chk("c_post_rst_adv", int'(adv_c), 1);
      chk("c_post_rst_busy", int'(busy_c), 0);
      tick();
      chk("c_post_rst_busy2", int'(busy_c), 0);

`ifdef STEP_CTRL_BREAK_EN
      // ---- breakpoint on dut_a: pc ramps 0x30..0x48, breaks at 0x40
      break_addr  = 32'h40;
      break_valid = 1'b1;
      for (int p = 'h30; p <= 'h48; p += 4) begin
         pc = 32'(p);
         tick();
         if (p < 'h40) begin
            chk($sformatf("brk_pc%0h_adv", p), int'(adv_a), 1);
            chk($sformatf("brk_pc%0h_hit", p), int'(hit_a), 0);
         end else begin
            chk($sformatf("brk_pc%0h_adv", p), int'(adv_a), 0);
            chk($sformatf("brk_pc%0h_hit", p), int'(hit_a), 1);
         end
      end
      break_valid = 1'b0;
      change = 1'b1;
      repeat (8) tick();
      change = 1'b0;
      repeat (4) tick();
      chk("brk_clear_mode", int'(mode_a), 0);
      chk("brk_clear_hit", int'(hit_a), 0);
      chk("brk_clear_adv", int'(adv_a), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
